// File: rtl/cpu_core_pkg.sv
// Shared definitions for the multicycle core: opcodes, instruction field slices
// and the controller state encoding.
package cpu_core_pkg;

   localparam int INSTR_BITS = 16;

   localparam int OP_MSB  = 15;
   localparam int OP_LSB  = 12;
   localparam int RD_MSB  = 11;
   localparam int RD_LSB  = 8;
   localparam int RS1_MSB = 7;
   localparam int RS1_LSB = 4;
   localparam int RS2_MSB = 3;
   localparam int RS2_LSB = 0;
   localparam int IMM_MSB = 7;
   localparam int IMM_LSB = 0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_MOV  = 4'h7;
   localparam logic [3:0] OP_JMP  = 4'h8;
   localparam logic [3:0] OP_BEQZ = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExecute,
      StWriteback,
      StHalted
   } state_e;

   function automatic logic op_writes_reg(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_MOV);
   endfunction

   function automatic logic op_sets_flags(input logic [3:0] op);
      return (op >= OP_ADD) && (op <= OP_XOR);
   endfunction

   // A..E are unassigned; they run as NOP but are reported.
   function automatic logic op_is_illegal(input logic [3:0] op);
      return (op >= 4'hA) && (op <= 4'hE);
   endfunction

endpackage

// File: rtl/cpu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous active-low clear. Indices at or above NREGS are inert.
module cpu_regfile
   import cpu_core_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned NREGS  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [3:0]        read_address1,
   input  logic [3:0]        read_address2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic [3:0]        write_address,
   input  logic              write_enable,
   input  logic [DATA_W-1:0] write_data
);

   // Full 4-bit index space; entries >= NREGS are never written and stay zero.
   logic [DATA_W-1:0] regs_q [16];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            regs_q[i] <= '0;
         end
      end else if (write_enable && (32'(write_address) < NREGS)) begin
         regs_q[write_address] <= write_data;
      end
   end

   always_comb begin
      read_data1 = '0;
      read_data2 = '0;
      if (32'(read_address1) < NREGS) read_data1 = regs_q[read_address1];
      if (32'(read_address2) < NREGS) read_data2 = regs_q[read_address2];
   end

endmodule

// File: rtl/multicycle_cpu_core.sv
// Multicycle core: FETCH/DECODE/EXECUTE/WRITEBACK controller with a handshaked
// instruction port, inline ALU, Z/C flags, halt and sticky illegal-opcode flag.
module multicycle_cpu_core
   import cpu_core_pkg::*;
#(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned NREGS   = 16,
   parameter int unsigned INSTR_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               run,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic [ADDR_W-1:0]  pc_address,
   output logic [INSTR_W-1:0] ir_instruction,
   output logic [3:0]         read_address1,
   output logic [3:0]         read_address2,
   output logic [DATA_W-1:0]  read_data1,
   output logic [DATA_W-1:0]  read_data2,
   output logic [3:0]         write_address,
   output logic               write_enable,
   output logic [DATA_W-1:0]  result,
   output logic               flag_z,
   output logic               flag_c,
   output logic               halted,
   output logic               illegal
);

   state_e state_q, state_d;

   logic [ADDR_W-1:0]  pc_q, next_pc_q, next_pc_d, pc_inc, imm_pc;
   logic [INSTR_W-1:0] ir_q;
   logic [DATA_W-1:0]  result_q, alu_res;
   logic               z_q, c_q, illegal_q, alu_c;
   logic [DATA_W:0]    add_full, sub_full;

   logic [3:0] op, rd, rs1, rs2;
   logic [7:0] imm8;

   assign op   = ir_q[OP_MSB:OP_LSB];
   assign rd   = ir_q[RD_MSB:RD_LSB];
   assign rs1  = ir_q[RS1_MSB:RS1_LSB];
   assign rs2  = ir_q[RS2_MSB:RS2_LSB];
   assign imm8 = ir_q[IMM_MSB:IMM_LSB];

   // BEQZ tests R[rd], so port 1 is steered to rd for that opcode.
   assign read_address1 = (op == OP_BEQZ) ? rd : rs1;
   assign read_address2 = rs2;
   assign write_address = rd;

   cpu_regfile #(
      .DATA_W (DATA_W),
      .NREGS  (NREGS)
   ) u_regfile (
      .clk           (clk),
      .reset         (reset),
      .read_address1 (read_address1),
      .read_address2 (read_address2),
      .read_data1    (read_data1),
      .read_data2    (read_data2),
      .write_address (write_address),
      .write_enable  (write_enable),
      .write_data    (result_q)
   );

   // SUB as a + ~b + 1 so the carry out is the no-borrow indication.
   assign add_full = {1'b0, read_data1} + {1'b0, read_data2};
   assign sub_full = {1'b0, read_data1} + {1'b0, ~read_data2} + (DATA_W+1)'(1);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op)
         OP_ADD:  {alu_c, alu_res} = add_full;
         OP_SUB:  {alu_c, alu_res} = sub_full;
         OP_AND:  alu_res = read_data1 & read_data2;
         OP_OR:   alu_res = read_data1 | read_data2;
         OP_XOR:  alu_res = read_data1 ^ read_data2;
         OP_LDI:  alu_res = DATA_W'(imm8);
         OP_MOV:  alu_res = read_data1;
         default: ;
      endcase
   end

   assign pc_inc = pc_q + ADDR_W'(1);
   assign imm_pc = imm8[ADDR_W-1:0];

   always_comb begin
      next_pc_d = pc_inc;
      if (op == OP_JMP) begin
         next_pc_d = imm_pc;
      end else if ((op == OP_BEQZ) && (read_data1 == '0)) begin
         next_pc_d = imm_pc;
      end
   end

   always_comb begin
      state_d      = state_q;
      imem_req     = 1'b0;
      write_enable = 1'b0;
      halted       = 1'b0;
      case (state_q)
         StIdle: begin
            if (run) state_d = StFetch;
         end
         StFetch: begin
            imem_req = 1'b1;
            if (imem_ack) state_d = StDecode;
         end
         StDecode:  state_d = StExecute;
         StExecute: state_d = StWriteback;
         StWriteback: begin
            write_enable = op_writes_reg(op);
            if (op == OP_HALT) begin
               state_d = StHalted;
            end else if (run) begin
               state_d = StFetch;
            end else begin
               state_d = StIdle;
            end
         end
         StHalted: halted = 1'b1;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         next_pc_q <= '0;
         ir_q      <= '0;
         result_q  <= '0;
         z_q       <= 1'b0;
         c_q       <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            StFetch: begin
               if (imem_ack) ir_q <= imem_rdata;
            end
            StExecute: begin
               result_q  <= alu_res;
               next_pc_q <= next_pc_d;
               if (op_sets_flags(op)) begin
                  z_q <= (alu_res == '0);
                  c_q <= alu_c;
               end
               if (op_is_illegal(op)) illegal_q <= 1'b1;
            end
            StWriteback: pc_q <= next_pc_q;
            default: ;
         endcase
      end
   end

   assign imem_addr      = pc_q;
   assign pc_address     = pc_q;
   assign ir_instruction = ir_q;
   assign result         = result_q;
   assign flag_z         = z_q;
   assign flag_c         = c_q;
   assign illegal        = illegal_q;

endmodule

// File: tb/tb_multicycle_cpu_core.sv
// Bench for multicycle_cpu_core: a memory responder with programmable ack delay
// and an instruction-level reference model checked at every fetch and writeback.
module tb_multicycle_cpu_core;

   logic        clk = 1'b0;
   logic        reset, run, imem_req, imem_ack;
   logic [7:0]  imem_addr, pc_address;
   logic [15:0] imem_rdata, ir_instruction;
   logic [3:0]  read_address1, read_address2, write_address;
   logic [7:0]  read_data1, read_data2, result;
   logic        write_enable, flag_z, flag_c, halted, illegal;

   multicycle_cpu_core dut (
      .clk            (clk),
      .reset          (reset),
      .run            (run),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .pc_address     (pc_address),
      .ir_instruction (ir_instruction),
      .read_address1  (read_address1),
      .read_address2  (read_address2),
      .read_data1     (read_data1),
      .read_data2     (read_data2),
      .write_address  (write_address),
      .write_enable   (write_enable),
      .result         (result),
      .flag_z         (flag_z),
      .flag_c         (flag_c),
      .halted         (halted),
      .illegal        (illegal)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   logic [15:0] mem [256];
   int          m_reg [16];
   int          m_pc, m_z, m_c, m_ill, m_halt;
   logic [15:0] m_ir;
   int          wb_rd_q[$];
   int          wb_val_q[$];
   int          cap_res [16];
   int          cap_z [16];
   int          cap_c [16];

   int dly = 1;
   int req_cnt = 0;
   bit mem_on = 1'b1;
   bit accepted;
   int acc_addr;
   int cycles = 0;
   int first_req = -1;
   int halt_at = -1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      foreach (m_reg[i]) m_reg[i] = 0;
      foreach (cap_res[i]) begin
         cap_res[i] = -1;
         cap_z[i]   = -1;
         cap_c[i]   = -1;
      end
      m_pc = 0; m_z = 0; m_c = 0; m_ill = 0; m_halt = 0; m_ir = '0;
      wb_rd_q.delete();
      wb_val_q.delete();
      first_req = -1;
      halt_at = -1;
   endtask

   // Architectural effect of one instruction, in plain integer arithmetic.
   task automatic model_exec(input logic [15:0] w);
      int op, rd, rs1, rs2, imm, a, b, r, nxt;
      op  = int'(w[15:12]);
      rd  = int'(w[11:8]);
      rs1 = int'(w[7:4]);
      rs2 = int'(w[3:0]);
      imm = int'(w[7:0]);
      a = m_reg[rs1];
      b = m_reg[rs2];
      r = 0;
      nxt = (m_pc + 1) % 256;
      case (op)
         1: begin r = a + b; m_c = (r > 255) ? 1 : 0; r = r % 256; end
         2: begin m_c = (a >= b) ? 1 : 0; r = (a - b + 256) % 256; end
         3: begin r = a & b; m_c = 0; end
         4: begin r = a | b; m_c = 0; end
         5: begin r = a ^ b; m_c = 0; end
         6: r = imm;
         7: r = a;
         8: nxt = imm;
         9: if (m_reg[rd] == 0) nxt = imm;
         10, 11, 12, 13, 14: m_ill = 1;
         15: m_halt = 1;
         default: ;
      endcase
      if (op >= 1 && op <= 5) m_z = (r == 0) ? 1 : 0;
      if (op >= 1 && op <= 7) begin
         m_reg[rd] = r;
         wb_rd_q.push_back(rd);
         wb_val_q.push_back(r);
      end
      m_pc = nxt;
   endtask

   // One clock: sample on the falling edge, check, then drive the memory side.
   task automatic cyc();
      int rd, v;
      @(posedge clk);
      @(negedge clk);
      cycles++;
      accepted = 1'b0;
      chk("ir_hold", ir_instruction, m_ir);
      if (imem_req === 1'b1 && first_req < 0) first_req = cycles;
      if (write_enable === 1'b1) begin
         if (wb_rd_q.size() == 0) begin
            chk("we_unexpected", write_enable, 0);
         end else begin
            rd = wb_rd_q.pop_front();
            v  = wb_val_q.pop_front();
            chk("wb_addr", write_address, rd);
            chk("wb_data", result, v);
            cap_res[write_address] = int'(result);
            cap_z[write_address]   = int'(flag_z);
            cap_c[write_address]   = int'(flag_c);
         end
      end
      if (mem_on) begin
         if (req_cnt > 0) chk("req_held", imem_req, 1);
         if (imem_req === 1'b1) begin
            req_cnt++;
            if (req_cnt >= dly) begin
               chk("fetch_addr", imem_addr, m_pc);
               chk("fetch_pc", pc_address, m_pc);
               chk("flag_z", flag_z, m_z);
               chk("flag_c", flag_c, m_c);
               chk("illegal", illegal, m_ill);
               chk("halted_in_fetch", halted, 0);
               chk("rdata2", read_data2, m_reg[m_ir[3:0]]);
               if (m_ir[15:12] != 4'h9) begin
                  chk("raddr1", read_address1, m_ir[7:4]);
                  chk("rdata1", read_data1, m_reg[m_ir[7:4]]);
               end
               imem_ack   = 1'b1;
               imem_rdata = mem[imem_addr];
               accepted   = 1'b1;
               acc_addr   = int'(imem_addr);
               m_ir       = mem[m_pc[7:0]];
               model_exec(mem[m_pc[7:0]]);
               req_cnt = 0;
            end else begin
               imem_ack = 1'b0;
            end
         end else begin
            imem_ack = 1'b0;
            req_cnt  = 0;
         end
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      run = 1'b0;
      imem_ack = 1'b0;
      req_cnt = 0;
      model_reset();
      cyc();
      cyc();
      reset = 1'b1;
      cyc();
   endtask

   task automatic fill_halt();
      foreach (mem[i]) mem[i] = 16'hF000;
   endtask

   task automatic run_to_halt(input string tag);
      int n;
      n = 0;
      run = 1'b1;
      while (halted !== 1'b1 && n < 3000) begin
         cyc();
         n++;
      end
      halt_at = cycles;
      chk({tag, "_halted"}, halted, 1);
      repeat (3) cyc();
      chk({tag, "_req_low"}, imem_req, 0);
      chk({tag, "_still_halted"}, halted, 1);
      chk({tag, "_wb_pending"}, wb_rd_q.size(), 0);
      chk({tag, "_pc"}, pc_address, m_pc);
   endtask

   initial begin
      int n, nf, op;
      logic [3:0] rsel;
      logic [7:0] rv;
      logic [11:0] fld;
      reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
      fill_halt();
      do_reset();

      chk("rst_pc", pc_address, 0);
      chk("rst_ir", ir_instruction, 0);
      chk("rst_req", imem_req, 0);
      chk("rst_we", write_enable, 0);
      chk("rst_halted", halted, 0);
      chk("rst_illegal", illegal, 0);
      chk("rst_flags", {flag_z, flag_c}, 0);
      chk("rst_result", result, 0);

      // LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT at zero wait.
      fill_halt();
      mem[0] = 16'h6105; mem[1] = 16'h6203; mem[2] = 16'h1312;
      dly = 1;
      run_to_halt("prog1");
      chk("p1_r3", cap_res[3], 8);
      chk("p1_r3_z", cap_z[3], 0);
      chk("p1_r3_c", cap_c[3], 0);
      chk("p1_latency", halt_at - first_req, 16);
      run = 1'b0;
      do_reset();

      // Carry/zero and no-borrow, then untaken and taken BEQZ.
      fill_halt();
      mem[0] = 16'h61FF; mem[1] = 16'h6201; mem[2] = 16'h1312; mem[3] = 16'h2421;
      mem[4] = 16'h9420; mem[5] = 16'h9030; mem[6] = 16'h7000;
      run_to_halt("prog2");
      chk("p2_add", cap_res[3], 0);
      chk("p2_add_z", cap_z[3], 1);
      chk("p2_add_c", cap_c[3], 1);
      chk("p2_sub", cap_res[4], 2);
      chk("p2_sub_c", cap_c[4], 0);
      chk("p2_pc_after_branch", pc_address, 8'h31);
      do_reset();

      // Illegal opcode then LDI.
      fill_halt();
      mem[0] = 16'hB000; mem[1] = 16'h655A;
      run_to_halt("illegal");
      chk("illegal_sticky", illegal, 1);
      chk("ldi_after_illegal", cap_res[5], 8'h5A);
      do_reset();

      // BEQZ loop with three-cycle ack delay.
      fill_halt();
      mem[0] = 16'h6100; mem[1] = 16'h9100;
      dly = 3;
      run = 1'b1;
      n = 0; nf = 0;
      while (nf < 8 && n < 300) begin
         cyc();
         if (accepted) nf++;
         n++;
      end
      chk("loop_fetches", nf, 8);
      run = 1'b0;
      repeat (12) cyc();
      chk("loop_park_req", imem_req, 0);
      chk("loop_park_pc", pc_address, 0);
      dly = 1;
      do_reset();

      // Reset while a fetch waits for ack; late ack must be ignored.
      fill_halt();
      mem[0] = 16'h6111; mem[1] = 16'h6222; mem[2] = 16'h6333;
      run = 1'b1;
      n = 0;
      while (!(accepted && acc_addr == 1) && n < 100) begin cyc(); n++; end
      dly = 10;
      n = 0;
      while (req_cnt < 3 && n < 100) begin cyc(); n++; end
      chk("pre_rst_pc", pc_address, 2);
      reset = 1'b0;
      mem_on = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 16'h6444;
      #1;
      chk("async_rst_req", imem_req, 0);
      chk("async_rst_pc", pc_address, 0);
      model_reset();
      req_cnt = 0;
      run = 1'b0;
      cyc();
      reset = 1'b1;
      cyc();
      cyc();
      chk("late_ack_ir", ir_instruction, 0);
      chk("late_ack_req", imem_req, 0);
      imem_ack = 1'b0;
      mem_on = 1'b1;
      dly = 1;
      do_reset();

      // PC wrap at 0xFF, park on run drop, resume at 0x00.
      fill_halt();
      mem[0] = 16'h80FF; mem[255] = 16'h0000;
      run = 1'b1;
      n = 0;
      while (!(accepted && acc_addr == 255) && n < 100) begin cyc(); n++; end
      run = 1'b0;
      repeat (8) cyc();
      chk("wrap_park_req", imem_req, 0);
      chk("wrap_park_pc", pc_address, 0);
      chk("wrap_not_halted", halted, 0);
      run = 1'b1;
      n = 0;
      accepted = 1'b0;
      while (!accepted && n < 20) begin cyc(); n++; end
      chk("wrap_resume_addr", acc_addr, 0);
      do_reset();

      // Random straight-line programs with random ack latency.
      for (int p = 0; p < 6; p++) begin
         fill_halt();
         dly = $urandom_range(1, 3);
         for (int r = 0; r < 16; r++) begin
            rsel = 4'(r);
            rv = 8'($urandom);
            mem[r] = {4'h6, rsel, rv};
         end
         for (int k = 0; k < 24; k++) begin
            op = $urandom_range(0, 12);
            if (op > 7) op = op + 2;
            fld = 12'($urandom);
            mem[16 + k] = {4'(op), fld};
         end
         run_to_halt("rand");
         do_reset();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/multicycle_cpu_core.md
Name: multicycle_cpu_core

Overview:
- Parametrised successor to the 8-bit single-issue CPU: same fetch/IR/decode/regfile/ALU pipeline of ideas, generalised in data width, register count and program-address width.
- Adds a handshaked instruction-memory port, a run/pause control, conditional branch, halt, flags and an illegal-opcode flag.
- Sits between the instruction memory and the system bench.
- Exposes the existing debug observability ports so the bench can monitor execution.

Parameters:
- DATA_W, 8, datapath/register width; legal range ≥8.
- ADDR_W, 8, program-counter width; legal range 1..8.
- NREGS, 16, register count; fixed by the 4-bit register fields, legal range 2..16.
- INSTR_W, 16, instruction width; fixed at 16.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- run  input  1  when 1, the core may leave IDLE and start a fetch.
- imem_req  output  1  fetch request; held high until imem_ack.
- imem_addr  output  ADDR_W  fetch address, equal to pc_address.
- imem_ack  input  1  memory response valid.
- imem_rdata  input  INSTR_W  instruction word; sampled when imem_req&&imem_ack.
- pc_address  output  ADDR_W  current PC.
- ir_instruction  output  INSTR_W  instruction register.
- read_address1 / read_address2  output  4  regfile read indices (rs1, rs2).
- read_data1 / read_data2  output  DATA_W  regfile read data.
- write_address  output  4  regfile write index.
- write_enable  output  1  regfile write strobe; one cycle, in WRITEBACK only.
- result  output  DATA_W  ALU/writeback value.
- flag_z / flag_c  output  1  zero and carry from the last ALU operation.
- halted  output  1  core in HALTED state.
- illegal  output  1  sticky; set on an undefined opcode.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE.
  - All outputs 0: PC, IR, flags, halted, illegal, imem_req, write_enable.
  - All registers cleared.
  - If reset asserts during an outstanding fetch, imem_req drops immediately and the ack is ignored.
- Instruction format:
  - op[15:12], rd[11:8], rs1[7:4], rs2[3:0].
  - imm8 = [7:0], zero-extended or truncated to DATA_W; jump/branch targets truncated to ADDR_W.
- Opcodes:
  - 0 NOP.
  - 1 ADD; 2 SUB, where C = no-borrow.
  - 3 AND; 4 OR; 5 XOR, each with C=0.
  - 6 LDI rd<=imm8.
  - 7 MOV rd<=rs1.
  - 8 JMP pc<=imm8.
  - 9 BEQZ: if R[rd]==0 then pc<=imm8, else pc+1.
  - F HALT.
  - A–E are illegal: executed as NOP and set illegal.
- Flags:
  - Z and C update only on ops 1–5.
  - Z = (result==0), computed at DATA_W width.
  - ADD and SUB wrap modulo 2^DATA_W; C = bit DATA_W of the (DATA_W+1)-bit sum/difference.
- FSM states: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALTED.
  - IDLE: imem_req=0. Go to FETCH when run==1.
  - FETCH: imem_req=1 and imem_addr=PC. On ack, IR<=imem_rdata and go to DECODE. An ack arriving in the same cycle as req is legal, so FETCH lasts ≥1 cycle.
  - DECODE: drive read_address1/2 from the IR. read_data is combinational from the regfile.
  - EXECUTE: latch result, flags and the next PC.
  - WRITEBACK: write_enable=1 for ops 1,2,3,4,5,6,7. PC <= next PC.
    - Then go to HALTED if op==F.
    - Otherwise FETCH if run==1, or IDLE if run==0.
  - HALTED: halted=1, imem_req=0. Leaves only on reset; run is ignored.
- Throughput: 4 cycles per instruction with zero-wait memory.
- PC increments modulo 2^ADDR_W, so 0xFF+1 wraps to 0x00 at ADDR_W=8.
- Register writes for rd ≥ NREGS are dropped; reads of index ≥ NREGS return 0.
- Dropping run mid-instruction completes that instruction, then the core parks in IDLE.

Decomposition:
- Package cpu_core_pkg holds:
  - the opcode localparams;
  - the state enum encoding;
  - the field-slice constants (OP_MSB, RD_LSB, …).
- Sub-module cpu_regfile: NREGS×DATA_W, 2 async read ports, 1 sync write port, async active-low clear.
- The ALU stays inline as a combinational case.

Test Plan:
- Program LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT with zero-wait memory:
  - R3 writeback result=0x08, flag_z=0, flag_c=0.
  - halted=1 at cycle 16 after run.
  - imem_req stays low thereafter.
- LDI R1,0xFF; LDI R2,1; ADD R3,R1,R2: result=0x00, flag_z=1, flag_c=1. Then SUB R4,R2,R1: result=0x02, flag_c=0.
- Loop LDI R1,0; BEQZ R1,0x00 with a 3-cycle ack delay:
  - imem_req is held 3 cycles per fetch.
  - PC alternates 0→1→0.
  - The IR is never updated without an ack.
- Opcode 0xB000 fetched: illegal=1 and stays set, no regfile write. A following LDI still executes.
- Reset driven low while FETCH is waiting for ack: imem_req=0 and pc_address=0 in the same cycle. A late ack is ignored.
- PC at 0xFF executing NOP: the next imem_addr is 0x00. Dropping run at WRITEBACK gives IDLE with imem_req=0, and re-raising run resumes at 0x00.
